// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder.
package systolic_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int N_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } feed_state_e;

  // Cycles needed for the last beat to cross the far corner PE after it leaves the feeder.
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Beat stream into the feeder: one A column and one W row per handshake.
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N      = N_DEF
) ();

  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] a_vec;
  logic [N*DATA_W-1:0] w_vec;

  modport master (output in_valid, output a_vec, output w_vec, input in_ready);
  modport slave  (input in_valid, input a_vec, input w_vec, output in_ready);

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain; lane i of the feeder uses DEPTH = i+1.
module skew_delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] d_i,
  output logic signed [DATA_W-1:0] q_o
);

  logic signed [DATA_W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Drives the left/top edges of an NxN systolic MAC grid with per-lane skew and job sequencing.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N      = N_DEF,
  parameter int K_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [K_W-1:0]        k_len,
  systolic_skew_feeder_if.slave in_if,
  output logic [N*DATA_W-1:0]   a_edge,
  output logic [N*DATA_W-1:0]   w_edge,
  output logic                  acc_clr,
  output logic                  busy,
  output logic                  done
);

  localparam int FLUSH_CYC = flush_cycles(N);
  localparam int FC_W      = $clog2(FLUSH_CYC + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYC - 1);

  feed_state_e     state_q;
  logic [K_W-1:0]  k_len_q;
  logic [K_W-1:0]  beat_cnt_q;
  logic [FC_W-1:0] flush_cnt_q;
  logic            xfer;

  assign xfer = in_if.in_valid && (state_q == STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            k_len_q     <= k_len;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            state_q     <= (k_len == '0) ? FLUSH : STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q + 1'b1 == k_len_q) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == FC_LAST) state_q <= DONE;
          else                        flush_cnt_q <= flush_cnt_q + 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // acc_clr is decoded from the IDLE+start condition so the clear lands in the start cycle itself.
  assign in_if.in_ready = (state_q == STREAM);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign acc_clr        = (state_q == IDLE) && start;

  // Stage p0: zero-injection mux, then lane i delays i+1 cycles.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [DATA_W-1:0] a_d, w_d, a_q, w_q;

    assign a_d = xfer ? in_if.a_vec[i*DATA_W +: DATA_W] : '0;
    assign w_d = xfer ? in_if.w_vec[i*DATA_W +: DATA_W] : '0;

    skew_delay_line #(.DATA_W(DATA_W), .DEPTH(i + 1)) u_a_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (a_d),
      .q_o   (a_q)
    );

    skew_delay_line #(.DATA_W(DATA_W), .DEPTH(i + 1)) u_w_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (w_d),
      .q_o   (w_q)
    );

    assign a_edge[i*DATA_W +: DATA_W] = a_q;
    assign w_edge[i*DATA_W +: DATA_W] = w_q;
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: transfer-log edge model, attached 4x4 MAC grid, directed jobs.
module tb_systolic_skew_feeder;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [N*DW-1:0] a_edge, w_edge;
  logic          acc_clr, busy, done;

  systolic_skew_feeder_if #(.DATA_W(DW), .N(N)) in_if ();

  systolic_skew_feeder #(.DATA_W(DW), .N(N), .K_W(KW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .k_len   (k_len),
    .in_if   (in_if),
    .a_edge  (a_edge),
    .w_edge  (w_edge),
    .acc_clr (acc_clr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] lane(input logic [N*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Attached PE grid: activations move right, weights move down, psum accumulates.
  logic signed [DW-1:0] a_reg [N][N];
  logic signed [DW-1:0] w_reg [N][N];
  logic signed [DW-1:0] a_in  [N][N];
  logic signed [DW-1:0] w_in  [N][N];
  longint               psum  [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_in[i][j] = '0;
        w_in[i][j] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = lane(a_edge, i);
      w_in[0][i] = lane(w_edge, i);
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_reg[i][j-1];
        w_in[j][i] = w_reg[j-1][i];
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!rst_n) begin
          a_reg[i][j] <= '0;
          w_reg[i][j] <= '0;
          psum[i][j]  <= 0;
        end else begin
          a_reg[i][j] <= a_in[i][j];
          w_reg[i][j] <= w_in[i][j];
          psum[i][j]  <= acc_clr ? 0 : psum[i][j] + longint'(a_in[i][j]) * longint'(w_in[i][j]);
        end
      end
    end
  end

  // Behavioural model: edges are the transfer log delayed by 1+lane; control from job rules.
  logic signed [DW-1:0] logA [64][N];
  logic signed [DW-1:0] logW [64][N];
  logic signed [DW-1:0] jobA [256][N];
  logic signed [DW-1:0] jobW [256][N];
  int mphase = 0;  // 0 idle, 1 streaming, 2 waiting for done
  int mk = 0, mcnt = 0, mdone_at = 0;

  initial begin : model
    bit xfer, exp_done;
    longint s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int x = 0; x < 64; x++)
          for (int i = 0; i < N; i++) begin
            logA[x][i] = '0;
            logW[x][i] = '0;
          end
        mphase = 0;
        chk("rst_a_edge", longint'(a_edge), 0);
        chk("rst_w_edge", longint'(w_edge), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_if.in_ready, 0);
      end else begin
        exp_done = (mphase == 2) && (cyc == mdone_at);
        chk("in_ready", in_if.in_ready, mphase == 1);
        chk("busy", busy, mphase != 0);
        chk("done", done, exp_done);
        chk("acc_clr", acc_clr, (mphase == 0) && start);
        for (int i = 0; i < N; i++) begin
          chk($sformatf("a_edge_lane%0d", i), lane(a_edge, i), logA[(cyc-1-i) & 63][i]);
          chk($sformatf("w_edge_lane%0d", i), lane(w_edge, i), logW[(cyc-1-i) & 63][i]);
        end
        if (exp_done) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              s = 0;
              for (int b = 0; b < mk; b++) s += longint'(jobA[b][i]) * longint'(jobW[b][j]);
              chk($sformatf("psum_%0d_%0d", i, j), psum[i][j], s);
            end
        end
        xfer = in_if.in_valid && (mphase == 1);
        for (int i = 0; i < N; i++) begin
          logA[cyc & 63][i] = xfer ? lane(in_if.a_vec, i) : '0;
          logW[cyc & 63][i] = xfer ? lane(in_if.w_vec, i) : '0;
          if (xfer) begin
            jobA[mcnt][i] = lane(in_if.a_vec, i);
            jobW[mcnt][i] = lane(in_if.w_vec, i);
          end
        end
        case (mphase)
          0: if (start) begin
            mk = int'(k_len);
            mcnt = 0;
            if (mk == 0) begin mdone_at = cyc + 2*N; mphase = 2; end
            else mphase = 1;
          end
          1: if (xfer) begin
            mcnt++;
            if (mcnt == mk) begin mdone_at = cyc + 2*N; mphase = 2; end
          end
          default: if (cyc == mdone_at) mphase = 0;
        endcase
      end
    end
  end

  // Stimulus
  int A_m [N][N];
  int W_m [N][N];
  int W0  [N][N];
  int W1  [N][N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int b, output int t);
    int g = 0;
    in_if.in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_if.a_vec[i*DW +: DW] = DW'(A_m[i][b]);
      in_if.w_vec[i*DW +: DW] = DW'(W_m[b][i]);
    end
    while (!in_if.in_ready && g < 20) begin step(); g++; end
    chk("beat_accepted", in_if.in_ready, 1);
    t = cyc;
    step();
    in_if.in_valid = 1'b0;
    in_if.a_vec    = '0;
    in_if.w_vec    = '0;
  endtask

  task automatic stream_beats(input int k, input bit bubbles, inout int t_last);
    for (int b = 0; b < k; b++) begin
      if (bubbles && b > 0) step();
      send_beat(b, t_last);
    end
  endtask

  task automatic wait_done(output int td, output bit any_ready);
    int g = 0;
    any_ready = 0;
    while (!done && g < 40) begin
      any_ready |= in_if.in_ready;
      step();
      g++;
    end
    chk("done_within_bound", done, 1);
    td = cyc;
  endtask

  task automatic set_identity_a();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) A_m[i][j] = (i == j) ? 1 : 0;
  endtask

  task automatic chk_psum(input string name, input int M [N][N]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_%0d_%0d", name, i, j), psum[i][j], M[i][j]);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, tl, td, t0;
    bit rdy;
    W0 = '{'{32767, -2, 3, 4}, '{5, 6, -7, 8}, '{9, 10, 11, -12}, '{-13, 14, 15, -32768}};
    W1 = '{'{-1, 100, -200, 7}, '{0, -32768, 1, 2}, '{3, 4, 32767, -5}, '{6, -7, 8, 9}};
    in_if.in_valid = 1'b0;
    in_if.a_vec    = '0;
    in_if.w_vec    = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Skew timing: one beat, A lanes {1,2,3,4}, W lanes {5,6,7,8}.
    for (int i = 0; i < N; i++) begin A_m[i][0] = i + 1; W_m[0][i] = 5 + i; end
    start = 1'b1; k_len = 8'd1;
    step();
    start = 1'b0;
    send_beat(0, t);
    for (int d = 1; d <= 5; d++) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("skew_a_d%0d_l%0d", d, i), lane(a_edge, i), (d == i + 1) ? i + 1 : 0);
        chk($sformatf("skew_w_d%0d_l%0d", d, i), lane(w_edge, i), (d == i + 1) ? i + 5 : 0);
      end
      step();
    end
    wait_done(td, rdy);
    chk("skew_done_time", td - t, 8);
    step();

    // Full job: A = I, W = W0.
    set_identity_a(); W_m = W0;
    start = 1'b1; k_len = 8'd4;
    #1 chk("job_acc_clr_at_start", acc_clr, 1);
    step();
    start = 1'b0;
    stream_beats(4, 1'b0, tl);
    wait_done(td, rdy);
    chk("job_done_time", td - tl, 8);
    chk_psum("job_psum", W0);
    step();

    // Same job with a bubble between beats.
    start = 1'b1; k_len = 8'd4;
    step();
    start = 1'b0;
    stream_beats(4, 1'b1, tl);
    wait_done(td, rdy);
    chk("bubble_done_time", td - tl, 8);
    chk_psum("bubble_psum", W0);
    step();

    // k_len = 0: flush only.
    start = 1'b1; k_len = 8'd0;
    #1 chk("k0_acc_clr", acc_clr, 1);
    t0 = cyc;
    step();
    start = 1'b0;
    wait_done(td, rdy);
    chk("k0_done_time", td - t0, 8);
    chk("k0_no_ready", rdy, 0);
    step();

    // Reset in the middle of a stream with non-zero edges.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin A_m[i][j] = 7; W_m[i][j] = -3; end
    start = 1'b1; k_len = 8'd4;
    step();
    start = 1'b0;
    stream_beats(2, 1'b0, tl);
    chk("pre_rst_edge_nonzero", lane(a_edge, 0), 7);
    rst_n = 1'b0;
    #1;
    chk("midrst_a_edge", longint'(a_edge), 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();

    // Back-to-back with start held: second job only launches from IDLE.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin A_m[i][j] = i + j + 1; W_m[i][j] = j - 3*i; end
    start = 1'b1; k_len = 8'd2;
    step();
    stream_beats(2, 1'b0, tl);
    wait_done(td, rdy);
    chk("b2b1_done_time", td - tl, 8);
    chk("b2b_no_clr_in_done", acc_clr, 0);
    k_len = 8'd4;
    set_identity_a(); W_m = W1;
    step();
    chk("b2b_clr_after_done", acc_clr, 1);
    step();
    start = 1'b0;
    stream_beats(4, 1'b0, tl);
    wait_done(td, rdy);
    chk("b2b2_done_time", td - tl, 8);
    chk_psum("b2b2_psum", W1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
